keypad_time_entry: RTL and testbench
====================================

KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 The block SHALL have parameter LOAD_PULSE_CYCLES, default 1, giving the number of clk cycles load_n is held low per commit (legal 1-15).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port key_valid, input, 1, a one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have port key_code, input, 4: 0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored.
REQ-006 The block SHALL have port busy, input, 1, high while the downstream digit counters are counting down.
REQ-007 The block SHALL have ports min_tens, min_units, sec_tens, sec_units, each output, 4, the BCD digits presented as parallel load data to the downstream BCD digit counters.
REQ-008 The block SHALL have port load_n, output, 1, an active-low registered strobe driving the digit counters' load inputs.
REQ-009 The block SHALL have port digit_count, output, 3, the number of digits entered (0-4).
REQ-010 The block SHALL have port entry_err, output, 1, a one-cycle pulse on any rejected key.

Function
REQ-011 The FSM SHALL have states IDLE (no digits), ENTRY (1-4 digits), LOAD (load_n low), and LOCKED (busy high).
REQ-012 A digit key in IDLE or ENTRY with digit_count<4 SHALL shift left (min_tens<=min_units<=sec_tens<=sec_units<=key) and increment digit_count, giving IDLE->ENTRY.
REQ-013 A digit key with digit_count==4 SHALL leave the digits unchanged and pulse entry_err.
REQ-014 A clear key in IDLE or ENTRY SHALL zero all digits and digit_count and go to IDLE in the following cycle.
REQ-015 An enter key in IDLE SHALL be ignored with an entry_err pulse.
REQ-016 An enter key in ENTRY with sec_tens<=5 SHALL drive load_n low starting the next cycle for exactly LOAD_PULSE_CYCLES cycles (state LOAD), then return load_n high.
REQ-017 An enter key in ENTRY with sec_tens>5 SHALL be handled per REQ-027/REQ-028.
REQ-018 After LOAD, the block SHALL go to LOCKED if busy==1, else IDLE; the digits SHALL be preserved in either case.
REQ-019 Whenever busy==1, the block SHALL enter LOCKED from IDLE or ENTRY and drop all keys without an entry_err pulse; busy going high in the same cycle as key_valid SHALL cause that key to be dropped.
REQ-020 On busy falling, LOCKED SHALL go to IDLE, zeroing all digits and digit_count.
REQ-021 During LOAD and LOCKED, digit outputs SHALL be stable (no change) and keys SHALL be ignored.
REQ-022 Ignored codes 4'hC-4'hF SHALL produce no state change and no entry_err pulse.
REQ-023 load_n and entry_err SHALL be driven directly from flops (glitch-free).

Reset
REQ-024 While clr==1, all digits and digit_count SHALL be 0, load_n SHALL be 1, entry_err SHALL be 0, and the state SHALL be IDLE, independent of clk.
REQ-025 clr asserted during LOAD SHALL immediately return load_n high and abort the commit.
REQ-026 After clr deasserts, the first key SHALL be accepted on the next rising clk edge.

Configuration
REQ-027 With macro SEC_NORMALIZE_EN defined, an enter key with seconds 60-99 SHALL convert the seconds to seconds-60 with minutes+1 in BCD before LOAD; if minutes==99, the time SHALL saturate to 99:59; normalized digits SHALL be valid on the first load_n low cycle.
REQ-028 Without SEC_NORMALIZE_EN, an enter key with sec_tens>5 SHALL be rejected: entry_err pulses, the state stays ENTRY, and the digits are unchanged.

Verification
REQ-029 Keys 1,3,0, enter -> digits 0,1,3,0; digit_count 3; load_n low 1 cycle starting the cycle after enter; busy=0 -> IDLE with digits 0130 held.
REQ-030 Keys 1,2,3,4,5 -> digits 1234; 5th key gives an entry_err pulse; clear -> 0000, digit_count 0.
REQ-031 Keys 9,9,9,9, enter: with macro -> load 99:59; without macro -> entry_err pulse, no load_n pulse, digits 9999; also keys 1,7,5, enter with macro -> load 02:15.
REQ-032 Enter in IDLE -> entry_err pulse, load_n stays 1; code 4'hE -> no effect.
REQ-033 Commit 0045 with busy rising during LOAD -> LOCKED; digit key during LOCKED has no effect; busy falls -> IDLE, digits 0000.
REQ-034 With LOAD_PULSE_CYCLES=3, assert clr in the second low cycle -> load_n high immediately and all outputs at reset values.

Source files
------------

// File: rtl/keypad_time_entry_if.sv
// Key input, busy status and BCD load-data bundle between the keypad front end
// (master) and keypad_time_entry (slave).
interface keypad_time_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       busy;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       load_n;
    logic [2:0] digit_count;
    logic       entry_err;

    modport master (
        output key_valid, key_code, busy,
        input  min_tens, min_units, sec_tens, sec_units, load_n, digit_count, entry_err
    );

    modport slave (
        input  key_valid, key_code, busy,
        output min_tens, min_units, sec_tens, sec_units, load_n, digit_count, entry_err
    );
endinterface

// File: rtl/keypad_time_entry.sv
// Keypad MM:SS entry that commits BCD digits to downstream counters via load_n.
// Optional macro SEC_NORMALIZE_EN: enter with seconds 60-99 rolls the excess into minutes.
module keypad_time_entry #(
    parameter int unsigned LOAD_PULSE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    keypad_time_entry_if.slave    bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] PULSE_LAST = 4'(LOAD_PULSE_CYCLES - 1);

`ifdef SEC_NORMALIZE_EN
    // Caller guarantees sec_tens > 5; 99:6x and above saturate to 99:59.
    function automatic logic [15:0] normalize_time(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        logic [15:0] r;
        mt = t[15:12];
        mu = t[11:8];
        st = t[7:4];
        su = t[3:0];
        if ((mt == 4'd9) && (mu == 4'd9)) begin
            r = {4'd9, 4'd9, 4'd5, 4'd9};
        end else if (mu == 4'd9) begin
            r = {mt + 4'd1, 4'd0, st - 4'd6, su};
        end else begin
            r = {mt, mu + 4'd1, st - 4'd6, su};
        end
        return r;
    endfunction
`endif

    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [15:0] digits_r;
    logic [15:0] digits_s;
    logic [15:0] shift_base_s;
    logic [2:0]  count_r;
    logic [2:0]  count_s;
    logic [3:0]  pulse_r;
    logic [3:0]  pulse_s;
    logic        load_n_r;
    logic        load_n_s;
    logic        err_r;
    logic        err_s;

    // Next-state, digit, strobe and error decode.
    always_comb begin
        state_s  = state_r;
        digits_s = digits_r;
        count_s  = count_r;
        pulse_s  = pulse_r;
        load_n_s = 1'b1;
        err_s    = 1'b0;
        // Digits left over from a previous commit are discarded when a new entry begins.
        if (state_r == ST_IDLE) begin
            shift_base_s = 16'h0000;
        end else begin
            shift_base_s = digits_r;
        end

        case (state_r)
            ST_IDLE, ST_ENTRY: begin
                if (bus.busy) begin
                    state_s = ST_LOCKED;
                end else if (bus.key_valid) begin
                    if (bus.key_code <= 4'd9) begin
                        if (count_r < 3'd4) begin
                            digits_s = {shift_base_s[11:0], bus.key_code};
                            count_s  = count_r + 3'd1;
                            state_s  = ST_ENTRY;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        digits_s = 16'h0000;
                        count_s  = 3'd0;
                        state_s  = ST_IDLE;
                    end else if (bus.key_code == KEY_ENTER) begin
                        if (state_r == ST_IDLE) begin
                            err_s = 1'b1;
                        end else if (digits_r[7:4] <= 4'd5) begin
                            state_s  = ST_LOAD;
                            load_n_s = 1'b0;
                            pulse_s  = PULSE_LAST;
                        end else begin
`ifdef SEC_NORMALIZE_EN
                            digits_s = normalize_time(digits_r);
                            state_s  = ST_LOAD;
                            load_n_s = 1'b0;
                            pulse_s  = PULSE_LAST;
`else
                            err_s = 1'b1;
`endif
                        end
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (pulse_r == 4'd0) begin
                    count_s = 3'd0;
                    if (bus.busy) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    load_n_s = 1'b0;
                    pulse_s  = pulse_r - 4'd1;
                end
            end
            ST_LOCKED: begin
                if (!bus.busy) begin
                    state_s  = ST_IDLE;
                    digits_s = 16'h0000;
                    count_s  = 3'd0;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                digits_s = 16'h0000;
                count_s  = 3'd0;
            end
        endcase
    end

    // State and output registers; clr forces load_n high at once, aborting any commit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= ST_IDLE;
            digits_r <= 16'h0000;
            count_r  <= 3'd0;
            pulse_r  <= 4'd0;
            load_n_r <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            digits_r <= digits_s;
            count_r  <= count_s;
            pulse_r  <= pulse_s;
            load_n_r <= load_n_s;
            err_r    <= err_s;
        end
    end

    assign bus.min_tens    = digits_r[15:12];
    assign bus.min_units   = digits_r[11:8];
    assign bus.sec_tens    = digits_r[7:4];
    assign bus.sec_units   = digits_r[3:0];
    assign bus.digit_count = count_r;
    assign bus.load_n      = load_n_r;
    assign bus.entry_err   = err_r;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed self-checking bench for keypad_time_entry (pulse widths 1 and 3).
module tb_keypad_time_entry;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    keypad_time_entry_if bus();
    keypad_time_entry_if bus3();

    assign bus3.key_valid = bus.key_valid;
    assign bus3.key_code  = bus.key_code;
    assign bus3.busy      = bus.busy;

    keypad_time_entry #(.LOAD_PULSE_CYCLES(1)) dut (.clk(clk), .clr(clr), .bus(bus));
    keypad_time_entry #(.LOAD_PULSE_CYCLES(3)) dut3 (.clk(clk), .clr(clr), .bus(bus3));

    wire [15:0] dig  = {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
    wire [15:0] dig3 = {bus3.min_tens, bus3.min_units, bus3.sec_tens, bus3.sec_units};

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clr = 1'b1;
        bus.busy = 1'b0;
        bus.key_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL reset_digits got %h want 0000", dig); end
        checks++; if (bus.digit_count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d want 0", bus.digit_count); end
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL reset_load_n got %b want 1", bus.load_n); end
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", bus.entry_err); end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_commit();
        apply_reset();
        press(4'd1); press(4'd3); press(4'd0);
        checks++; if (dig !== 16'h0130) begin failures++; $display("FAIL commit_digits got %h want 0130", dig); end
        checks++; if (bus.digit_count !== 3'd3) begin failures++; $display("FAIL commit_count got %0d want 3", bus.digit_count); end
        press(4'hB);
        checks++; if (bus.load_n !== 1'b0) begin failures++; $display("FAIL commit_load_low got %b want 0", bus.load_n); end
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL commit_no_err got %b want 0", bus.entry_err); end
        @(negedge clk);
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL commit_load_release got %b want 1", bus.load_n); end
        checks++; if (dig !== 16'h0130) begin failures++; $display("FAIL commit_hold got %h want 0130", dig); end
        press(4'hB);
        checks++; if (bus.entry_err !== 1'b1) begin failures++; $display("FAIL commit_back_idle_err got %b want 1", bus.entry_err); end
    endtask

    task automatic test_overflow_clear();
        apply_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        checks++; if (bus.entry_err !== 1'b1) begin failures++; $display("FAIL overflow_err got %b want 1", bus.entry_err); end
        checks++; if (dig !== 16'h1234) begin failures++; $display("FAIL overflow_digits got %h want 1234", dig); end
        checks++; if (bus.digit_count !== 3'd4) begin failures++; $display("FAIL overflow_count got %0d want 4", bus.digit_count); end
        @(negedge clk);
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL overflow_err_pulse got %b want 0", bus.entry_err); end
        press(4'hA);
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL clear_digits got %h want 0000", dig); end
        checks++; if (bus.digit_count !== 3'd0) begin failures++; $display("FAIL clear_count got %0d want 0", bus.digit_count); end
    endtask

    task automatic test_sec_range();
        apply_reset();
        press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'hB);
`ifdef SEC_NORMALIZE_EN
        checks++; if (bus.load_n !== 1'b0) begin failures++; $display("FAIL sat_load got %b want 0", bus.load_n); end
        checks++; if (dig !== 16'h9959) begin failures++; $display("FAIL sat_digits got %h want 9959", dig); end
        apply_reset();
        press(4'd1); press(4'd7); press(4'd5); press(4'hB);
        checks++; if (bus.load_n !== 1'b0) begin failures++; $display("FAIL norm_load got %b want 0", bus.load_n); end
        checks++; if (dig !== 16'h0215) begin failures++; $display("FAIL norm_digits got %h want 0215", dig); end
`else
        checks++; if (bus.entry_err !== 1'b1) begin failures++; $display("FAIL secrej_err got %b want 1", bus.entry_err); end
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL secrej_load got %b want 1", bus.load_n); end
        checks++; if (dig !== 16'h9999) begin failures++; $display("FAIL secrej_digits got %h want 9999", dig); end
        @(negedge clk);
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL secrej_no_pulse got %b want 1", bus.load_n); end
        press(4'hB);
        checks++; if (bus.entry_err !== 1'b1) begin failures++; $display("FAIL secrej_still_entry got %b want 1", bus.entry_err); end
`endif
    endtask

    task automatic test_idle_keys();
        apply_reset();
        press(4'hB);
        checks++; if (bus.entry_err !== 1'b1) begin failures++; $display("FAIL idle_enter_err got %b want 1", bus.entry_err); end
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL idle_enter_load got %b want 1", bus.load_n); end
        press(4'd5);
        press(4'hE);
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL ignored_err got %b want 0", bus.entry_err); end
        checks++; if (dig !== 16'h0005) begin failures++; $display("FAIL ignored_digits got %h want 0005", dig); end
        checks++; if (bus.digit_count !== 3'd1) begin failures++; $display("FAIL ignored_count got %0d want 1", bus.digit_count); end
    endtask

    task automatic test_locked();
        apply_reset();
        press(4'd0); press(4'd0); press(4'd4); press(4'd5); press(4'hB);
        checks++; if (bus.load_n !== 1'b0) begin failures++; $display("FAIL lock_load got %b want 0", bus.load_n); end
        bus.busy = 1'b1;
        @(negedge clk);
        checks++; if (bus.load_n !== 1'b1) begin failures++; $display("FAIL lock_load_release got %b want 1", bus.load_n); end
        press(4'd7);
        checks++; if (dig !== 16'h0045) begin failures++; $display("FAIL lock_digits got %h want 0045", dig); end
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL lock_no_err got %b want 0", bus.entry_err); end
        bus.busy = 1'b0;
        @(negedge clk);
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL unlock_digits got %h want 0000", dig); end
        checks++; if (bus.digit_count !== 3'd0) begin failures++; $display("FAIL unlock_count got %0d want 0", bus.digit_count); end
        press(4'd8);
        checks++; if (dig !== 16'h0008) begin failures++; $display("FAIL unlock_accept got %h want 0008", dig); end
    endtask

    task automatic test_busy_drop();
        apply_reset();
        press(4'd3);
        @(negedge clk);
        bus.busy = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code = 4'd4;
        @(negedge clk);
        bus.key_valid = 1'b0;
        checks++; if (dig !== 16'h0003) begin failures++; $display("FAIL busykey_digits got %h want 0003", dig); end
        checks++; if (bus.entry_err !== 1'b0) begin failures++; $display("FAIL busykey_err got %b want 0", bus.entry_err); end
        bus.busy = 1'b0;
        @(negedge clk);
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL busykey_release got %h want 0000", dig); end
    endtask

    task automatic test_clr_during_load();
        apply_reset();
        press(4'd1); press(4'd2); press(4'hB);
        checks++; if (bus3.load_n !== 1'b0) begin failures++; $display("FAIL p3_low1 got %b want 0", bus3.load_n); end
        @(negedge clk);
        checks++; if (bus3.load_n !== 1'b0) begin failures++; $display("FAIL p3_low2 got %b want 0", bus3.load_n); end
        #2 clr = 1'b1;
        #1;
        checks++; if (bus3.load_n !== 1'b1) begin failures++; $display("FAIL p3_clr_load got %b want 1", bus3.load_n); end
        checks++; if (dig3 !== 16'h0000) begin failures++; $display("FAIL p3_clr_digits got %h want 0000", dig3); end
        checks++; if (bus3.digit_count !== 3'd0) begin failures++; $display("FAIL p3_clr_count got %0d want 0", bus3.digit_count); end
        checks++; if (bus3.entry_err !== 1'b0) begin failures++; $display("FAIL p3_clr_err got %b want 0", bus3.entry_err); end
        @(negedge clk);
        clr = 1'b0;
        press(4'd6);
        checks++; if (dig3 !== 16'h0006) begin failures++; $display("FAIL p3_first_key got %h want 0006", dig3); end
        checks++; if (bus3.load_n !== 1'b1) begin failures++; $display("FAIL p3_after_load got %b want 1", bus3.load_n); end
    endtask

    initial begin
        clr = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code = 4'h0;
        bus.busy = 1'b0;
        test_reset();
        test_commit();
        test_overflow_clear();
        test_sec_range();
        test_idle_keys();
        test_locked();
        test_busy_drop();
        test_clr_during_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
